// File: rtl/shift_row_stream.sv
// shift_row_stream
// Byte-serial, double-buffered AES ShiftRows (INVERSE=0) or InvShiftRows
// (INVERSE=1). Sixteen state bytes arrive in index order 0..15 and are written
// into one of two 16x8 banks. A completed bank is read out in output index
// order, with each read address permuted so that the row rotation happens on
// the read side. Ping-pong banking sustains one byte per cycle in each
// direction.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (control state only)
//   abort      discards the partially written bank; has priority over in_valid
//   in_valid   in_byte is valid this cycle
//   in_ready   the block accepts a byte this cycle (rst, abort and flops only)
//   in_byte    state byte, index order 0..15
//   out_valid  out_byte is valid this cycle
//   out_ready  the sink accepts out_byte this cycle
//   out_byte   permuted state byte, index order 0..15 (8'h00 when idle)
//   out_last   marks byte 15 of an output block
module shift_row_stream #(
    parameter bit INVERSE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last
);

    // Byte storage: two banks of sixteen bytes.
    logic [7:0] bank_mem [2][16];

    // Control state.
    logic       wbank_q, wbank_d;
    logic [3:0] wcnt_q,  wcnt_d;
    logic       rbank_q, rbank_d;
    logic [3:0] rcnt_q,  rcnt_d;
    logic [1:0] full_q,  full_d;

    logic       in_fire;
    logic       out_fire;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic [3:0] rd_idx;

    // A bank can only be written while empty and only read while full, so the
    // write and read sides never touch the same bank at the same time.
    assign in_ready  = ~rst & ~abort & ~full_q[wbank_q];
    assign in_fire   = in_valid & in_ready;
    assign out_valid = full_q[rbank_q];
    assign out_fire  = out_valid & out_ready;

    // Read-address permutation: output byte 4r+c comes from stored byte
    // 4r+((c+r) mod 4) forward, or 4r+((c-r) mod 4) inverse. The 2-bit
    // column arithmetic wraps modulo 4 on its own.
    always_comb begin
        rd_row = rcnt_q[3:2];
        rd_col = INVERSE ? (rcnt_q[1:0] - rd_row) : (rcnt_q[1:0] + rd_row);
        rd_idx = {rd_row, rd_col};
    end

    assign out_byte = out_valid ? bank_mem[rbank_q][rd_idx] : 8'h00;
    assign out_last = out_valid & (rcnt_q == 4'd15);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;

        if (in_fire) begin
            if (wcnt_q == 4'd15) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = 4'd0;
            end else begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end

        // abort restarts the current write bank; in_ready is already low so
        // no byte is accepted in the same cycle.
        if (abort) begin
            wcnt_d = 4'd0;
        end

        // Clearing full[rbank] never collides with setting full[wbank]:
        // they are different banks whenever both happen.
        if (out_fire) begin
            if (rcnt_q == 4'd15) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcnt_d          = 4'd0;
            end else begin
                rcnt_d = rcnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q <= 1'b0;
            wcnt_q  <= 4'd0;
            rbank_q <= 1'b0;
            rcnt_q  <= 4'd0;
            full_q  <= 2'b00;
        end else begin
            wbank_q <= wbank_d;
            wcnt_q  <= wcnt_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
        end
    end

    // NOTE: the bank storage has no reset; full_q guards every read, so stale
    // contents are never visible and the array can map onto plain storage.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bank_mem[wbank_q][wcnt_q] <= in_byte;
        end
    end

endmodule

// File: tb/tb_shift_row_stream.sv
// Testbench for shift_row_stream. Runs a forward and an inverse instance side by
// side on shared stimulus and compares both against a block-level model: a
// queue of completed 16-byte blocks, each permuted with the row-rotation rule.
module tb_shift_row_stream;

    typedef logic [7:0] blk_t [16];

    typedef struct {
        logic [7:0] in_b;
        logic [7:0] exp_fwd;
        logic [7:0] exp_inv;
        logic       exp_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, abort, in_valid, out_ready;
    logic [7:0] in_byte;
    logic       in_ready_f, out_valid_f, out_last_f;
    logic       in_ready_i, out_valid_i, out_last_i;
    logic [7:0] out_byte_f, out_byte_i;

    always #5 clk = ~clk;

    shift_row_stream #(.INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_f), .in_byte(in_byte),
        .out_valid(out_valid_f), .out_ready(out_ready),
        .out_byte(out_byte_f), .out_last(out_last_f)
    );

    shift_row_stream #(.INVERSE(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_i), .in_byte(in_byte),
        .out_valid(out_valid_i), .out_ready(out_ready),
        .out_byte(out_byte_i), .out_last(out_last_i)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    blk_t fwd_q[$];
    blk_t inv_q[$];
    blk_t part;
    int   pcnt = 0;
    int   rd   = 0;

    // Values sampled during the most recent cycle.
    logic       s_valid, s_last, s_ready;
    logic [7:0] s_fwd, s_inv;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic blk_t permute(input blk_t b, input bit inv);
        blk_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[4*r+c] = b[4*r + (inv ? ((c - r + 4) % 4) : ((c + r) % 4))];
            end
        end
        return o;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, clock,
    // then advance the model by the handshakes that took place.
    task automatic cycle(input logic iv, input logic [7:0] ib, input logic orr,
                         input logic ab, input logic rs);
        logic       has, acc, xfer, exp_rdy;
        logic [7:0] ef, ei;
        in_valid  = iv;
        in_byte   = ib;
        out_ready = orr;
        abort     = ab;
        rst       = rs;
        #2;
        has     = (fwd_q.size() > 0);
        ef      = has ? fwd_q[0][rd] : 8'h00;
        ei      = has ? inv_q[0][rd] : 8'h00;
        exp_rdy = !rs && !ab && (fwd_q.size() < 2);
        check_bit("in_ready_fwd", in_ready_f, exp_rdy);
        check_bit("in_ready_inv", in_ready_i, exp_rdy);
        if (!rs) begin
            check_bit("out_valid_fwd", out_valid_f, has);
            check_bit("out_valid_inv", out_valid_i, has);
            check_bit("out_last_fwd", out_last_f, has && (rd == 15));
            check_bit("out_last_inv", out_last_i, has && (rd == 15));
            check_byte("out_byte_fwd", out_byte_f, ef);
            check_byte("out_byte_inv", out_byte_i, ei);
        end
        s_valid = out_valid_f;
        s_last  = out_last_f;
        s_ready = in_ready_f;
        s_fwd   = out_byte_f;
        s_inv   = out_byte_i;
        @(posedge clk);
        if (rs) begin
            fwd_q.delete();
            inv_q.delete();
            pcnt = 0;
            rd   = 0;
        end else begin
            acc  = exp_rdy && iv;
            xfer = has && orr;
            if (acc) begin
                part[pcnt] = ib;
                pcnt++;
                if (pcnt == 16) begin
                    fwd_q.push_back(permute(part, 1'b0));
                    inv_q.push_back(permute(part, 1'b1));
                    pcnt = 0;
                end
            end
            if (ab) pcnt = 0;
            if (xfer) begin
                rd++;
                if (rd == 16) begin
                    void'(fwd_q.pop_front());
                    void'(inv_q.pop_front());
                    rd = 0;
                end
            end
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t       vecs [16];
        logic [7:0] fw [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h04,
                                8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0F, 8'h0C, 8'h0D, 8'h0E};
        logic [7:0] iw [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                                8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
        int         idle;
        int         seen;
        logic [7:0] first_byte;
        logic       got_first;

        for (int i = 0; i < 16; i++) begin
            vecs[i].in_b     = 8'(i);
            vecs[i].exp_fwd  = fw[i];
            vecs[i].exp_inv  = iw[i];
            vecs[i].exp_last = (i == 15);
        end

        // Reset, then idle outputs on the first cycle after.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_bit("reset_in_ready", s_ready, 1'b1);
        check_bit("reset_out_valid", s_valid, 1'b0);
        check_byte("reset_out_byte", s_fwd, 8'h00);

        // Table-driven block 00..0F, both permutations and latency.
        for (int k = 0; k < 32; k++) begin
            cycle(k < 16, (k < 16) ? vecs[k % 16].in_b : 8'h00, 1'b1, 1'b0, 1'b0);
            if (k == 15) check_bit("tbl_latency", s_valid, 1'b0);
            if (k >= 16) begin
                check_bit("tbl_valid", s_valid, 1'b1);
                check_byte("tbl_fwd", s_fwd, vecs[k-16].exp_fwd);
                check_byte("tbl_inv", s_inv, vecs[k-16].exp_inv);
                check_bit("tbl_last", s_last, vecs[k-16].exp_last);
            end
        end

        // Back-to-back: 48 bytes gap-free, no idle output between blocks.
        idle = 0;
        for (int k = 0; k < 64; k++) begin
            cycle(k < 48, 8'(k), 1'b1, 1'b0, 1'b0);
            if (k < 48) check_bit("b2b_in_ready", s_ready, 1'b1);
            if (k >= 16 && !s_valid) idle++;
            if (k == 32) check_byte("b2b_blk2_byte0", s_fwd, 8'h10);
            if (k == 36) check_byte("b2b_blk2_byte4", s_fwd, 8'h15);
        end
        check_byte("b2b_idle_cycles", 8'(idle), 8'd0);

        // Backpressure: two banks fill, then drain one block.
        for (int k = 0; k < 32; k++) cycle(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_bit("bp_in_ready_low", s_ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (k < 15) check_bit("bp_still_full", s_ready, 1'b0);
            if (k == 15) check_bit("bp_last", s_last, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_bit("bp_in_ready_back", s_ready, 1'b1);
        drain(17);

        // abort on byte 07 discards 00..07.
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        check_bit("abort_in_ready", s_ready, 1'b0);
        seen = 0;
        got_first = 1'b0;
        first_byte = 8'h00;
        for (int k = 0; k < 34; k++) begin
            cycle(k < 16, 8'(8'h40 + k), 1'b1, 1'b0, 1'b0);
            if (s_valid && !got_first) begin
                got_first  = 1'b1;
                first_byte = s_fwd;
            end
            if (s_valid && s_fwd < 8'h08) seen++;
        end
        check_byte("abort_first_byte", first_byte, 8'h40);
        check_byte("abort_stale_bytes", 8'(seen), 8'd0);

        // Reset with one full bank plus five bytes buffered.
        for (int k = 0; k < 21; k++) cycle(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_bit("rst_mid_out_valid", s_valid, 1'b0);
        check_bit("rst_mid_in_ready", s_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (s_valid) seen++;
        end
        check_byte("rst_mid_no_output", 8'(seen), 8'd0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'(8'hE0 + k), 1'b1, 1'b0, 1'b0);
        drain(17);

        // Randomized traffic with occasional abort and reset.
        for (int k = 0; k < 800; k++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom()), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
